mul_sequencer: RTL and testbench
================================

# mul_sequencer

Controller that sequences the shared, unsigned, fixed-latency `array_multiplier` on behalf of the execute stage to implement RV32M MUL, MULH, MULHSU and MULHU. It converts operands to magnitudes, presents them to the multiplier, and waits out the multiplier latency. It then applies sign correction, selects the high or low word, and returns the result with a one-cycle `resp` pulse. A single-entry product-reuse register returns back-to-back requests on identical operands (e.g. MULH then MUL) in one cycle without touching the multiplier.

## Interface
- `MUL_LATENCY`, 4: clock edges from `mul_a`/`mul_b` stable to `mul_ans` valid; legal range 1..15.
- `ENABLE_REUSE`, 1: 1 enables the product-reuse register; 0 makes every request a miss.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  multiply request; `op`/`rs1`/`rs2` held stable while high until `resp`.
- `op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `rs1`, `rs2`  in  32 each  operands.
- `flush`  in  1  abort any in-flight request; no `resp` is produced for it.
- `resp`  out  1  one-cycle pulse; `rdata` valid.
- `rdata`  out  32  result; holds its value until the next `resp`.
- `busy`  out  1  high in BUSY and DONE.
- `mul_a`, `mul_b`  out  32 each  registered magnitudes to the multiplier.
- `mul_ans`  in  64  unsigned product from the multiplier.

## Operation
- FSM: IDLE, BUSY, DONE.
- **IDLE:**
  - `req & ~flush`, reuse hit: go to DONE.
  - `req & ~flush`, miss: latch operands, load counter with `MUL_LATENCY`, go to BUSY.
  - `flush` has priority over `req`.
- **Operand modes:**
  - SS for MULH: abs(rs1), abs(rs2); negate = rs1[31]^rs2[31].
  - SU for MULHSU: abs(rs1), rs2; negate = rs1[31].
  - UU for MULHU and for a MUL miss: no conversion; negate = 0.
  - abs(0x80000000) = 0x80000000 when read as unsigned magnitude.
- **BUSY:** counter decrements each cycle.
  - At zero: capture `mul_ans` into the product register and go to DONE.
  - `flush` in BUSY: go to IDLE, discard the product, leave the reuse entry unchanged.
- **DONE:**
  - Corrected product P = negate ? (~prod + 1) : prod, 64-bit.
  - `rdata` = P[31:0] for MUL, else P[63:32].
  - `resp` = 1; go to IDLE.
  - On a miss, write the reuse entry {valid, rs1, rs2, mode, prod}.
  - `flush` in DONE does not suppress `resp`.
- **Reuse hit:** valid, and stored rs1/rs2 equal the request.
  - MUL hits in any stored mode, since the corrected low word is mode-independent.
  - MULH, MULHSU and MULHU hit only when the stored mode matches.
- **Requester rule:** `req` in DONE is ignored. If `req` is still high in the following IDLE cycle, it is a new request, normally a hit. The datapath deasserts `req` the cycle after `resp`.

## Timing
- Reset values (async, `rst`=0): state IDLE, `resp` 0, `rdata` 0, `busy` 0, `mul_a`/`mul_b` 0, reuse valid 0, counter 0.
- Miss latency:
  - Accept in cycle 0.
  - `mul_a`/`mul_b` valid from cycle 1.
  - `mul_ans` sampled at the end of cycle `MUL_LATENCY`.
  - `resp` in cycle `MUL_LATENCY`+1.
- Hit latency: accept in cycle 0, `resp` in cycle 1.
- Throughput: at most one request outstanding; the next accept is no earlier than the cycle after `resp`.
- `mul_a`/`mul_b` change only on a miss accept and are stable through BUSY.
- Reset asserted mid-operation: immediate return to IDLE, no `resp`, reuse entry invalidated.

## Test plan
- MULHU 0xFFFFFFFF×0xFFFFFFFF (miss) -> `resp` at cycle 5 (`MUL_LATENCY`=4), `rdata`=0xFFFFFFFE. Then MUL with the same operands -> hit, `resp` at cycle 1, `rdata`=0x00000001, `mul_a`/`mul_b` unchanged.
- MULH 0xFFFFFFFF×0x00000002 -> `rdata`=0xFFFFFFFF. MULH 0x80000000×0x80000000 -> 0x40000000.
- MULHSU 0x80000000×0xFFFFFFFF -> `rdata`=0x80000000. A following MULHU on the same operands misses (mode mismatch) -> 0x7FFFFFFF.
- MUL 0x00000007×0xFFFFFFFD -> `rdata`=0xFFFFFFEB. Repeated at `MUL_LATENCY`=1 -> `resp` at cycle 2.
- Miss accepted, `flush` at cycle 2 -> no `resp`, `busy` 0 at cycle 3. Same request reissued -> treated as a miss, full latency.
- `rst` pulled low in BUSY -> outputs at reset values immediately. A MUL that would have hit before reset misses afterwards.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequences a shared unsigned fixed-latency multiplier to implement RV32M MUL/MULH/MULHSU/MULHU,
// with a single-entry product-reuse register for back-to-back requests on identical operands.
module mul_sequencer #(
    parameter int MUL_LATENCY  = 4,
    parameter bit ENABLE_REUSE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        resp,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_ans
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] MODE_UU = 2'd0;
    localparam logic [1:0] MODE_SS = 2'd1;
    localparam logic [1:0] MODE_SU = 2'd2;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] l_rs1, l_rs2;
    logic [1:0]  l_op, l_mode;
    logic        l_neg;
    logic        e_valid;
    logic [31:0] e_rs1, e_rs2;
    logic [1:0]  e_mode;
    logic [63:0] e_prod;

    logic [1:0]  req_mode;
    logic [31:0] abs1, abs2, opa, opb;
    logic        hit;

    function automatic logic negate_of(input logic [1:0] mode, input logic s1, input logic s2);
        case (mode)
            MODE_SS: return s1 ^ s2;
            MODE_SU: return s1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] correct(input logic [63:0] p, input logic n);
        return n ? (~p + 64'd1) : p;
    endfunction

    function automatic logic [31:0] pick(input logic [63:0] p, input logic [1:0] o);
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always_comb begin
        req_mode = MODE_UU;
        case (op)
            2'b01:   req_mode = MODE_SS;
            2'b10:   req_mode = MODE_SU;
            default: req_mode = MODE_UU;
        endcase
    end

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign abs1 = rs1[31] ? (~rs1 + 32'd1) : rs1;
    assign abs2 = rs2[31] ? (~rs2 + 32'd1) : rs2;
    assign opa  = (req_mode == MODE_UU) ? rs1 : abs1;
    assign opb  = (req_mode == MODE_SS) ? abs2 : rs2;

    // The corrected low word is the same in every mode, so MUL hits on any stored mode.
    assign hit = ENABLE_REUSE && e_valid && (rs1 == e_rs1) && (rs2 == e_rs2)
                 && ((op == 2'b00) || (req_mode == e_mode));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            resp    <= 1'b0;
            rdata   <= 32'd0;
            busy    <= 1'b0;
            mul_a   <= 32'd0;
            mul_b   <= 32'd0;
            l_rs1   <= 32'd0;
            l_rs2   <= 32'd0;
            l_op    <= 2'd0;
            l_mode  <= MODE_UU;
            l_neg   <= 1'b0;
            e_valid <= 1'b0;
            e_rs1   <= 32'd0;
            e_rs2   <= 32'd0;
            e_mode  <= MODE_UU;
            e_prod  <= 64'd0;
        end else begin
            resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !flush) begin
                        busy <= 1'b1;
                        if (hit) begin
                            state <= DONE;
                            resp  <= 1'b1;
                            rdata <= pick(correct(e_prod, negate_of(e_mode, rs1[31], rs2[31])), op);
                        end else begin
                            state  <= BUSY;
                            cnt    <= 4'(MUL_LATENCY);
                            mul_a  <= opa;
                            mul_b  <= opb;
                            l_rs1  <= rs1;
                            l_rs2  <= rs2;
                            l_op   <= op;
                            l_mode <= req_mode;
                            l_neg  <= negate_of(req_mode, rs1[31], rs2[31]);
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else if (cnt <= 4'd1) begin
                        // Last wait cycle: the multiplier output is valid now.
                        state <= DONE;
                        cnt   <= 4'd0;
                        resp  <= 1'b1;
                        rdata <= pick(correct(mul_ans, l_neg), l_op);
                        if (ENABLE_REUSE) begin
                            e_valid <= 1'b1;
                            e_rs1   <= l_rs1;
                            e_rs2   <= l_rs2;
                            e_mode  <= l_mode;
                            e_prod  <= mul_ans;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus queues expected (rdata, latency), monitors compare on resp.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        flush;
    logic        resp0, resp1, busy0, busy1;
    logic [31:0] rdata0, rdata1, mul_a0, mul_b0, mul_a1, mul_b1;
    logic [63:0] mul_ans0, mul_ans1;
    logic [63:0] pipe [3];

    always #5 clk = ~clk;

    mul_sequencer #(.MUL_LATENCY(4), .ENABLE_REUSE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req(req0), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
        .resp(resp0), .rdata(rdata0), .busy(busy0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_ans(mul_ans0)
    );

    mul_sequencer #(.MUL_LATENCY(1), .ENABLE_REUSE(1'b1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req(req1), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
        .resp(resp1), .rdata(rdata1), .busy(busy1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_ans(mul_ans1)
    );

    // Multiplier models: three register stages give a product valid in cycle 4 after the
    // operands appear in cycle 1; the latency-1 instance uses a combinational product.
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_a0} * {32'd0, mul_b0};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign mul_ans0 = pipe[2];
    assign mul_ans1 = {32'd0, mul_a1} * {32'd0, mul_b1};

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          t0;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   id_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp0 === 1'b1) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut unexpected_resp: got rdata %0h, expected no response", rdata0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check($sformatf("v%0d rdata", e.id), rdata0, e.data);
                check($sformatf("v%0d latency", e.id), cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (resp1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut_l1 unexpected_resp: got rdata %0h, expected no response", rdata1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check($sformatf("v%0d rdata_l1", e.id), rdata1, e.data);
                check($sformatf("v%0d latency_l1", e.id), cyc - e.t0, e.lat);
            end
        end
    end

    task automatic do_req(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input int exp_lat);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        op = o;
        rs1 = a;
        rs2 = b;
        if (sel) req1 = 1'b1;
        else     req0 = 1'b1;
        e.data = exp_d;
        e.lat  = exp_lat;
        e.t0   = cyc;
        e.id   = id_cnt;
        id_cnt++;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? resp1 : resp0) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL v%0d timeout: got no resp in 40 cycles, expected resp after %0d", e.id, exp_lat);
            if (sel) void'(q1.pop_back());
            else     void'(q0.pop_back());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        rs1 = 32'd0;
        rs2 = 32'd0;
        #1 rst = 1'b0;
        #1;
        check("reset resp", resp0, 0);
        check("reset rdata", rdata0, 0);
        check("reset busy", busy0, 0);
        check("reset mul_a", mul_a0, 0);
        check("reset mul_b", mul_b0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Latency-1 instance: miss completes in cycle 2.
        do_req(1'b1, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);

        do_req(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        do_req(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        check("hit mul_a", mul_a0, 32'hFFFF_FFFF);
        check("hit mul_b", mul_b0, 32'hFFFF_FFFF);
        do_req(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5);
        check("mulh mul_a", mul_a0, 32'h0000_0001);
        check("mulh mul_b", mul_b0, 32'h0000_0002);
        do_req(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5);
        do_req(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5);
        do_req(1'b0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5);
        do_req(1'b0, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);
        do_req(1'b0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 1);

        // Flush mid-flight: no response, idle the cycle after the flush.
        @(posedge clk);
        #1;
        op = 2'b00;
        rs1 = 32'd3;
        rs2 = 32'd5;
        req0 = 1'b1;
        @(posedge clk);
        #1;
        check("busy in flight", busy0, 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("busy after flush", busy0, 0);
        flush = 1'b0;
        req0 = 1'b0;
        do_req(1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 5);
        do_req(1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 1);

        // Reset in BUSY: outputs clear at once and the reuse entry is lost.
        @(posedge clk);
        #1;
        op = 2'b11;
        rs1 = 32'd9;
        rs2 = 32'd9;
        req0 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset resp", resp0, 0);
        check("midreset busy", busy0, 0);
        check("midreset rdata", rdata0, 0);
        check("midreset mul_a", mul_a0, 0);
        check("midreset mul_b", mul_b0, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 5);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
